// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO and shifts each word out as a UART frame
module fifo_uart_tx #(
  parameter int bits       = 8,
  parameter int clk_div    = 16,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] fifo_data,
  input  logic            fifo_pndng,
  output logic            fifo_pop,
  input  logic            enable,
  output logic            tx,
  output logic            busy
);
  localparam int CW = clk_div > 2 ? $clog2(clk_div) : 1;
  localparam int BW = bits > 2 ? $clog2(bits) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(clk_div - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(bits - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [bits-1:0] shift_q, shift_d;
  logic par_q, par_d, tx_q, tx_d, last;
  assign last = baud_q == BAUD_LAST;
  always_comb begin
    state_d = state_q;
    baud_d = baud_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    if (state_q != IDLE) baud_d = last ? '0 : baud_q + CW'(1);
    unique case (state_q)
      IDLE: ;
      START: if (last) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q == BIT_LAST ? '0 : bit_q + BW'(1);
        if (bit_q == BIT_LAST) state_d = parity_en != 0 ? PARITY : STOP;
      end
      PARITY: if (last) state_d = STOP;
      STOP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pop is held off during reset so the FIFO never loses a word to a dead frame
    fifo_pop = rst && enable && fifo_pndng && (state_q == IDLE || (state_q == STOP && last));
    if (fifo_pop) begin
      state_d = START;
      baud_d = '0;
      shift_d = fifo_data;
      par_d = (^fifo_data) ^ (parity_odd != 0);
    end
    // tx is registered from next-state values so the line never glitches
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
  end
  assign tx = tx_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmitter that drains the FIFO: watches the FIFO's pending flag, pops one word at a time and shifts it out as an asynchronous UART frame.
- Sits directly downstream of the fifo block.
- Connections: fifo Dout → fifo_data, fifo pndng → fifo_pndng, fifo_pop → fifo pop.
- Frame format: start bit, data bits LSB first, optional parity bit, one stop bit.

Parameters:
- bits, 8: data word width; must match the FIFO width.
- clk_div, 16: clk cycles per serial bit; legal range ≥ 2.
- parity_en, 0: 1 inserts a parity bit after the data bits.
- parity_odd, 0: parity sense when parity_en=1. 0 = even (total ones over data+parity is even), 1 = odd.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- fifo_data  in  bits  FIFO read data; valid whenever fifo_pndng=1
- fifo_pndng  in  1  FIFO holds at least one unread word
- fifo_pop  out  1  one-cycle pop strobe to the FIFO
- enable  in  1  allows new frames to start
- tx  out  1  serial line, idle high
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset (rst=0, asynchronous, may occur mid-frame):
  - state=IDLE; tx=1; fifo_pop=0; busy=0; shift register, bit counter, baud counter, parity accumulator all cleared.
  - Any partial frame is abandoned and not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop handshake:
  - fifo_pop is a combinational function of state, enable and fifo_pndng.
  - It is 1 only in two cases: (a) in IDLE with enable=1 and fifo_pndng=1; (b) in the final cycle of STOP with enable=1 and fifo_pndng=1.
  - In the cycle fifo_pop=1, fifo_data is captured into the shift register at that rising edge, parity is initialised from the data word, and the next state is START.
  - fifo_pop is never asserted when fifo_pndng=0, and is never high two consecutive cycles.
- Baud timing:
  - The baud counter counts 0..clk_div-1 in every non-IDLE state; each bit is held on tx for exactly clk_div cycles.
  - A state or bit transition occurs in the cycle the counter equals clk_div-1; the counter then wraps to 0.
- START: tx=0 for clk_div cycles, then DATA.
- DATA:
  - tx = shift_reg[0]; the register shifts right once per bit period.
  - Bit counter runs 0..bits-1.
  - After bit bits-1: go to PARITY if parity_en=1, otherwise STOP.
- PARITY: tx = XOR of the data word, inverted when parity_odd=1; lasts clk_div cycles.
- STOP:
  - tx=1 for clk_div cycles.
  - In the final cycle: pop condition true → START (back-to-back, no idle gap); otherwise → IDLE.
- Latency: tx falls on the clock edge that ends the pop cycle, i.e. first start-bit cycle is the cycle after fifo_pop=1.
- Frame length: (2 + bits + parity_en) × clk_div cycles.
- busy = (state != IDLE). It is 0 during the IDLE pop cycle and rises with START.
- enable deasserted mid-frame: the current frame completes normally; no further pop until enable=1.
- fifo_pndng dropping mid-frame: no effect on the current frame.
- FIFO empty at end of STOP: return to IDLE with tx=1.
- Output timing: tx is glitch-free and driven from the registered state and shift register only.
- Counter widths: $clog2(clk_div) and $clog2(bits) bits. The counters wrap only via the explicit compare, never by overflow.

Test Plan:
- Reset: hold rst=0 for 3 cycles with fifo_pndng=1 → tx=1, fifo_pop=0, busy=0 throughout. Release → fifo_pop=1 on the first cycle with enable=1.
- Single frame (bits=8, clk_div=4, parity_en=0): fifo_data=0xA5 → one pop pulse, then tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). Then busy=0 and tx=1.
- Parity (parity_en=1, clk_div=4): 0xA5 with parity_odd=0 → parity bit 0; parity_odd=1 → parity bit 1. 0x07 with parity_odd=0 → parity bit 1. Frame is 44 cycles.
- Back-to-back: FIFO preloaded with 0x01, 0x80, 0xFF → three pops, each in the last STOP cycle of the previous frame. tx has no idle cycles between frames; 120 cycles total at clk_div=4.
- Flow control: enable=0 with fifo_pndng=1 → no pop, tx stays 1. Drop enable mid-frame → the frame finishes and no new pop occurs. Raise enable → pop on the next cycle.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 and busy=0 immediately (asynchronous). After release, the next FIFO word is sent as a complete new frame.
